// File: rtl/cpu_pkg.sv
// Shared encodings and ALU operation type for the single-cycle MIPS-subset core.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational 32-bit ALU; zero flag drives the branch decision.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select; overflow is deliberately ignored
    always_comb begin
        result = 32'h0000_0000;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: result = 32'h0000_0000;
        endcase
    end

    assign zero = (result == 32'h0000_0000);

endmodule

// File: rtl/cpu_core.sv
// Single-cycle MIPS-subset core: fetch, decode, execute and write back each clock.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        initialize,
    input  logic [31:0] instruction_initialize_data,
    input  logic [31:0] instruction_initialize_address
);

    logic [31:0] imem    [IMEM_WORDS];
    logic [31:0] dmem    [DMEM_WORDS];
    logic [31:0] regfile [32];
    logic [31:0] pc;

    logic [31:0] instr_s;
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s, rt_s, rd_s;
    logic [15:0] imm_s;
    logic [31:0] rs_val_s, rt_val_s, sext_s;
    logic [31:0] pc_plus4_s, br_target_s;

    alu_op_e     alu_op_s;
    logic [31:0] alu_b_s, alu_result_s;
    logic        alu_zero_s;

    logic        reg_we_s;
    logic [4:0]  wr_idx_s;
    logic [31:0] wr_data_s;
    logic        mem_we_s;
    logic [31:0] pc_d;
    logic        unused_bits;

    assign instr_s     = imem[pc[9:2]];
    assign op_s        = instr_s[31:26];
    assign rs_s        = instr_s[25:21];
    assign rt_s        = instr_s[20:16];
    assign rd_s        = instr_s[15:11];
    assign funct_s     = instr_s[5:0];
    assign imm_s       = instr_s[15:0];
    assign sext_s      = sext16(imm_s);
    assign rs_val_s    = regfile[rs_s];
    assign rt_val_s    = regfile[rt_s];
    assign pc_plus4_s  = pc + 32'd4;
    assign br_target_s = pc_plus4_s + {sext_s[29:0], 2'b00};
    assign unused_bits = ^{instruction_initialize_address[31:10],
                           instruction_initialize_address[1:0], instr_s[10:6]};

    alu u_alu (
        .a      (rs_val_s),
        .b      (alu_b_s),
        .op     (alu_op_s),
        .result (alu_result_s),
        .zero   (alu_zero_s)
    );

    // Decode and next-pc selection; unrecognised encodings fall through as NOP
    always_comb begin
        alu_op_s  = ALU_ADD;
        alu_b_s   = rt_val_s;
        reg_we_s  = 1'b0;
        wr_idx_s  = rd_s;
        wr_data_s = alu_result_s;
        mem_we_s  = 1'b0;
        pc_d      = pc_plus4_s;
        case (op_s)
            OP_RTYPE: begin
                reg_we_s = 1'b1;
                case (funct_s)
                    F_ADD:   alu_op_s = ALU_ADD;
                    F_SUB:   alu_op_s = ALU_SUB;
                    F_AND:   alu_op_s = ALU_AND;
                    F_OR:    alu_op_s = ALU_OR;
                    F_SLT:   alu_op_s = ALU_SLT;
                    default: reg_we_s = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_b_s  = sext_s;
                wr_idx_s = rt_s;
                reg_we_s = 1'b1;
            end
            OP_LUI: begin
                wr_idx_s  = rt_s;
                wr_data_s = {imm_s, 16'h0000};
                reg_we_s  = 1'b1;
            end
            OP_LW: begin
                alu_b_s   = sext_s;
                wr_idx_s  = rt_s;
                wr_data_s = dmem[alu_result_s[9:2]];
                reg_we_s  = 1'b1;
            end
            OP_SW: begin
                alu_b_s  = sext_s;
                mem_we_s = 1'b1;
            end
            OP_BEQ: begin
                alu_op_s = ALU_SUB;
                if (alu_zero_s) pc_d = br_target_s;
                else            pc_d = pc_plus4_s;
            end
            OP_BNE: begin
                alu_op_s = ALU_SUB;
                if (!alu_zero_s) pc_d = br_target_s;
                else             pc_d = pc_plus4_s;
            end
            OP_J: begin
                pc_d = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
            end
            default: pc_d = pc_plus4_s;
        endcase
    end

    // Architectural state; a load in progress stalls the core
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'h0000_0000;
            for (int i = 0; i < 32; i++) regfile[i] <= 32'(i);
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= 32'h0000_0000;
        end else if (!initialize) begin
            pc <= pc_d;
            if (reg_we_s && (wr_idx_s != 5'd0)) regfile[wr_idx_s] <= wr_data_s;
            if (mem_we_s) dmem[alu_result_s[9:2]] <= rt_val_s;
        end
    end

    // Instruction memory survives reset so a program can be loaded under rst
    always_ff @(posedge clk) begin
        if (initialize) imem[instruction_initialize_address[9:2]] <= instruction_initialize_data;
    end

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: expectations queued with each stimulus phase, checked against probes.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        initialize = 1'b0;
    logic [31:0] init_data = 32'h0;
    logic [31:0] init_addr = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        bit          is_pc;
        int          idx;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    cpu_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .initialize                     (initialize),
        .instruction_initialize_data    (init_data),
        .instruction_initialize_address (init_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        return {6'h00, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic exp_reg(input string tag, input int idx, input logic [31:0] v);
        sb.push_back('{tag, 1'b0, idx, v});
    endtask

    task automatic exp_pc(input string tag, input logic [31:0] v);
        sb.push_back('{tag, 1'b1, 0, v});
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.is_pc ? dut.pc : dut.regfile[e.idx];
            check_eq(e.tag, act, e.exp);
        end
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        initialize = 1'b1;
        init_addr  = addr;
        init_data  = data;
        @(posedge clk);
    endtask

    task automatic release_all();
        @(negedge clk);
        initialize = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_prog_a();
        load(32'd0,  rtype(5'd0, 5'd4, 5'd8, 6'h22));       // SUB R8,R0,R4
        load(32'd4,  rtype(5'd8, 5'd0, 5'd4, 6'h2A));       // SLT R4,R8,R0
        load(32'd8,  itype(6'h08, 5'd1, 5'd2, 16'hFFB8));   // ADDI R2,R1,-72
        load(32'd12, {6'h02, 26'd4});                        // J 16
        load(32'd16, rtype(5'd0, 5'd2, 5'd1, 6'h20));       // ADD R1,R0,R2
        load(32'd20, rtype(5'd5, 5'd6, 5'd7, 6'h25));       // OR R7,R5,R6
        load(32'd24, itype(6'h05, 5'd0, 5'd1, 16'hFFFF));   // BNE R0,R1,-1
        load(32'd32, itype(6'h0F, 5'd0, 5'd9, 16'h0009));   // LUI R9,9
    endtask

    task automatic exp_prog_a(input string pfx);
        exp_reg({pfx, "_r8"}, 8, 32'hFFFF_FFFC);
        exp_reg({pfx, "_r4"}, 4, 32'h0000_0001);
        exp_reg({pfx, "_r2"}, 2, 32'hFFFF_FFB9);
        exp_reg({pfx, "_r1"}, 1, 32'hFFFF_FFB9);
        exp_reg({pfx, "_r7"}, 7, 32'h0000_0007);
        exp_reg({pfx, "_r9"}, 9, 32'h0000_0009);
        exp_pc ({pfx, "_pc"}, 32'd24);
    endtask

    initial begin
        // Reset state with nothing loaded
        run(2);
        exp_pc ("rst_pc", 32'd0);
        exp_reg("rst_r4", 4, 32'd4);
        exp_reg("rst_r31", 31, 32'd31);
        exp_reg("rst_r0", 0, 32'd0);
        drain();

        // Program A, with a stall inserted after two instructions
        load_prog_a();
        release_all();
        run(2);
        initialize = 1'b1;
        init_addr  = 32'd28;
        init_data  = 32'h0000_0000;
        run(3);
        exp_pc ("stall_pc", 32'd8);
        exp_reg("stall_r2", 2, 32'd2);
        exp_reg("stall_r8", 8, 32'hFFFF_FFFC);
        drain();
        initialize = 1'b0;
        run(12);
        exp_prog_a("runA");
        drain();
        run(5);
        exp_pc("loop_pc", 32'd24);
        drain();

        // Asynchronous reset between edges, then identical rerun
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(3);
        #2 rst = 1'b1;
        #1;
        exp_pc ("arst_pc", 32'd0);
        exp_reg("arst_r8", 8, 32'd8);
        exp_reg("arst_r4", 4, 32'd4);
        exp_reg("arst_r1", 1, 32'd1);
        drain();
        release_all();
        run(14);
        exp_prog_a("rerun");
        drain();

        // Program B: LUI/SW/LW, write to R0, branch to self at 40
        rst = 1'b1;
        load(32'd0,  itype(6'h0F, 5'd0, 5'd9, 16'h1234));   // LUI R9,0x1234
        load(32'd4,  itype(6'h2B, 5'd0, 5'd9, 16'h0008));   // SW R9,8(R0)
        load(32'd8,  itype(6'h23, 5'd0, 5'd10, 16'h0008));  // LW R10,8(R0)
        load(32'd12, rtype(5'd4, 5'd5, 5'd0, 6'h20));       // ADD R0,R4,R5
        load(32'd16, {6'h02, 26'd10});                       // J 40
        load(32'd40, itype(6'h04, 5'd0, 5'd0, 16'hFFFF));   // BEQ R0,R0,-1
        release_all();
        run(10);
        exp_reg("lui_r9", 9, 32'h1234_0000);
        exp_reg("lw_r10", 10, 32'h1234_0000);
        exp_reg("r0_zero", 0, 32'd0);
        exp_reg("r7_untouched", 7, 32'd7);
        exp_pc ("beq_pc", 32'd40);
        drain();
        run(20);
        exp_pc("beq_pc_hold", 32'd40);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
